// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: round-robin between CPU (port 0) and DMA/debug (port 1),
// with bounded locked bursts for port 1 and registered load return per port.
module dm_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [1:0]        p0_size,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [1:0]        p1_size,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic              p1_lock,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_stall,
    output logic [31:0]       p0_rdata,
    output logic [31:0]       p1_rdata,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_din,
    output logic              m_we,
    output logic              m_sb,
    output logic              m_lb,
    output logic              m_lbu,
    input  logic [31:0]       m_dout
);

    typedef enum logic {PREFER_P0, PREFER_P1} rr_t;

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    rr_t        rr, rr_next;
    logic [3:0] bcnt, bcnt_next;
    logic       burst_hold;
    logic       p0_rv_q, p1_rv_q;
    logic [7:0] lane;
    logic [31:0] load_data;

    // A burst is only held while it is already running and still under its limit.
    assign burst_hold = (bcnt != 4'd0) && p1_req && p1_lock && (bcnt < BMAX);

    always_comb begin
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        rr_next   = rr;
        bcnt_next = 4'd0;
        if (rst_n) begin
            if (burst_hold)
                p1_gnt = 1'b1;
            else if (p0_req && p1_req) begin
                if (rr == PREFER_P1)
                    p1_gnt = 1'b1;
                else
                    p0_gnt = 1'b1;
            end
            else if (p0_req)
                p0_gnt = 1'b1;
            else if (p1_req)
                p1_gnt = 1'b1;
        end
        if (p0_gnt)
            rr_next = PREFER_P1;
        else if (p1_gnt)
            rr_next = PREFER_P0;
        if (p1_gnt && p1_lock)
            bcnt_next = burst_hold ? bcnt + 4'd1 : 4'd1;
    end

    assign p0_stall = p0_req && !p0_gnt;

    always_comb begin
        m_addr = '0;
        m_din  = '0;
        m_we   = 1'b0;
        m_sb   = 1'b0;
        m_lb   = 1'b0;
        m_lbu  = 1'b0;
        if (p0_gnt) begin
            m_addr = p0_addr;
            m_din  = p0_wdata;
            m_we   = p0_we;
            m_sb   = p0_we && (p0_size == 2'b01 || p0_size == 2'b10);
            m_lb   = !p0_we && (p0_size == 2'b01);
            m_lbu  = !p0_we && (p0_size == 2'b10);
        end
        else if (p1_gnt) begin
            m_addr = p1_addr;
            m_din  = p1_wdata;
            m_we   = p1_we;
            m_sb   = p1_we && (p1_size == 2'b01 || p1_size == 2'b10);
            m_lb   = !p1_we && (p1_size == 2'b01);
            m_lbu  = !p1_we && (p1_size == 2'b10);
        end
    end

    // Little-endian byte lane select and extension of the memory's word output.
    always_comb begin
        lane = m_dout[7:0];
        case (m_addr[1:0])
            2'd1:    lane = m_dout[15:8];
            2'd2:    lane = m_dout[23:16];
            2'd3:    lane = m_dout[31:24];
            default: lane = m_dout[7:0];
        endcase
        if (m_lb)
            load_data = {{24{lane[7]}}, lane};
        else if (m_lbu)
            load_data = {24'd0, lane};
        else
            load_data = m_dout;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr       <= PREFER_P0;
            bcnt     <= 4'd0;
            p0_rv_q  <= 1'b0;
            p1_rv_q  <= 1'b0;
            p0_rdata <= 32'd0;
            p1_rdata <= 32'd0;
        end
        else begin
            rr      <= rr_next;
            bcnt    <= bcnt_next;
            p0_rv_q <= p0_gnt && !p0_we;
            p1_rv_q <= p1_gnt && !p1_we;
            if (p0_gnt && !p0_we)
                p0_rdata <= load_data;
            if (p1_gnt && !p1_we)
                p1_rdata <= load_data;
        end
    end

    // Masking with rst_n drops a pending rvalid as soon as reset is asserted.
    assign p0_rvalid = p0_rv_q && rst_n;
    assign p1_rvalid = p1_rv_q && rst_n;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: arbitration vector table plus load/store sequences
// against a simple byte-lane data memory model.
module tb_dm_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [1:0]  p0_size, p1_size;
    logic [11:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_stall, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [11:0] m_addr;
    logic [31:0] m_din, m_dout;
    logic        m_we, m_sb, m_lb, m_lbu;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:1023];

    typedef struct {
        logic rstn, r0, r1, lock, g0, g1, stall;
    } vec_t;

    vec_t vecs [17];

    dm_arbiter #(.ADDR_W(12), .BURST_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_stall(p0_stall),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .m_addr(m_addr), .m_din(m_din), .m_we(m_we), .m_sb(m_sb), .m_lb(m_lb), .m_lbu(m_lbu),
        .m_dout(m_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word-wide memory with byte-lane writes; read is combinational.
    assign m_dout = mem[m_addr[11:2]];

    always @(posedge clk) begin
        if (m_we) begin
            if (m_sb)
                mem[m_addr[11:2]][m_addr[1:0]*8 +: 8] <= m_din[7:0];
            else
                mem[m_addr[11:2]] <= m_din;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [1:0] size, input logic [11:0] addr,
                                 input logic [31:0] data, input logic lock);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = data;
        end
        else begin
            p1_req = req; p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = data;
            p1_lock = lock;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        rst_n = 1'b0;
        applyStimulus(0, 1, 1, 2'b00, 12'h010, 32'hDEADBEEF, 0);
        applyStimulus(1, 1, 1, 2'b01, 12'h020, 32'hCAFEF00D, 1);

        // Requests are masked during reset.
        #2;
        checkOutput("rst p0_gnt", p0_gnt, 0);
        checkOutput("rst p1_gnt", p1_gnt, 0);
        checkOutput("rst m_we", m_we, 0);
        checkOutput("rst m_sb", m_sb, 0);
        checkOutput("rst m_addr", m_addr, 0);
        tick();
        tick();
        checkOutput("rst p0_rvalid", p0_rvalid, 0);
        checkOutput("rst p1_rvalid", p1_rvalid, 0);
        checkOutput("rst p0_rdata", p0_rdata, 0);
        checkOutput("rst p1_rdata", p1_rdata, 0);

        // p0 word store followed by a load of the same word.
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 2'b00, 12'h000, 32'd0, 0);
        applyStimulus(0, 1, 1, 2'b00, 12'h010, 32'h12345678, 0);
        #2;
        checkOutput("st p0_gnt", p0_gnt, 1);
        checkOutput("st m_we", m_we, 1);
        checkOutput("st m_sb", m_sb, 0);
        checkOutput("st m_addr", m_addr, 12'h010);
        checkOutput("st m_din", m_din, 32'h12345678);
        tick();
        applyStimulus(0, 1, 0, 2'b00, 12'h010, 32'd0, 0);
        #2;
        checkOutput("ld p0_gnt", p0_gnt, 1);
        checkOutput("ld m_we", m_we, 0);
        checkOutput("st no rvalid", p0_rvalid, 0);
        tick();
        applyStimulus(0, 0, 0, 2'b00, 12'h000, 32'd0, 0);
        #2;
        checkOutput("ld p0_rvalid", p0_rvalid, 1);
        checkOutput("ld p0_rdata", p0_rdata, 32'h12345678);
        tick();
        checkOutput("ld p0_rvalid pulse", p0_rvalid, 0);

        // p1 word store, then three back-to-back byte loads.
        applyStimulus(1, 1, 1, 2'b00, 12'h020, 32'h80FF7F01, 0);
        tick();
        applyStimulus(1, 1, 0, 2'b01, 12'h023, 32'd0, 0);
        #2;
        checkOutput("lb m_lb", m_lb, 1);
        checkOutput("lb m_lbu", m_lbu, 0);
        tick();
        applyStimulus(1, 1, 0, 2'b10, 12'h023, 32'd0, 0);
        #2;
        checkOutput("lb3 rvalid", p1_rvalid, 1);
        checkOutput("lb3 rdata", p1_rdata, 32'hFFFFFF80);
        checkOutput("lbu m_lbu", m_lbu, 1);
        tick();
        applyStimulus(1, 1, 0, 2'b01, 12'h020, 32'd0, 0);
        #2;
        checkOutput("lbu3 rvalid", p1_rvalid, 1);
        checkOutput("lbu3 rdata", p1_rdata, 32'h00000080);
        tick();
        applyStimulus(1, 0, 0, 2'b00, 12'h000, 32'd0, 0);
        #2;
        checkOutput("lb0 rvalid", p1_rvalid, 1);
        checkOutput("lb0 rdata", p1_rdata, 32'h00000001);
        checkOutput("idle m_lb", m_lb, 0);
        tick();
        checkOutput("lb0 rvalid pulse", p1_rvalid, 0);

        // p1 byte store into a zero word, then word load back.
        applyStimulus(1, 1, 1, 2'b01, 12'h031, 32'h123456AB, 0);
        #2;
        checkOutput("sb m_sb", m_sb, 1);
        checkOutput("sb m_we", m_we, 1);
        tick();
        applyStimulus(1, 1, 0, 2'b00, 12'h030, 32'd0, 0);
        #2;
        checkOutput("sb next m_sb", m_sb, 0);
        checkOutput("sb no rvalid", p1_rvalid, 0);
        checkOutput("sb rdata held", p1_rdata, 32'h00000001);
        tick();
        applyStimulus(1, 0, 0, 2'b00, 12'h000, 32'd0, 0);
        #2;
        checkOutput("sb word rvalid", p1_rvalid, 1);
        checkOutput("sb word rdata", p1_rdata, 32'h0000AB00);
        tick();

        // Arbitration table: reset, alternation, full burst, truncated burst.
        vecs[0]  = '{0, 1, 1, 0, 0, 0, 1};
        vecs[1]  = '{1, 1, 1, 0, 1, 0, 0};
        vecs[2]  = '{1, 1, 1, 0, 0, 1, 1};
        vecs[3]  = '{1, 1, 1, 0, 1, 0, 0};
        vecs[4]  = '{1, 1, 1, 0, 0, 1, 1};
        vecs[5]  = '{1, 1, 1, 0, 1, 0, 0};
        vecs[6]  = '{1, 1, 1, 1, 0, 1, 1};
        vecs[7]  = '{1, 1, 1, 1, 0, 1, 1};
        vecs[8]  = '{1, 1, 1, 1, 0, 1, 1};
        vecs[9]  = '{1, 1, 1, 1, 0, 1, 1};
        vecs[10] = '{1, 1, 1, 1, 1, 0, 0};
        vecs[11] = '{1, 1, 1, 1, 0, 1, 1};
        vecs[12] = '{1, 1, 1, 1, 0, 1, 1};
        vecs[13] = '{1, 1, 1, 0, 1, 0, 0};
        vecs[14] = '{1, 0, 1, 0, 0, 1, 0};
        vecs[15] = '{1, 0, 0, 0, 0, 0, 0};
        vecs[16] = '{1, 1, 0, 0, 1, 0, 0};
        for (int i = 0; i < 17; i++) begin
            rst_n = vecs[i].rstn;
            applyStimulus(0, vecs[i].r0, 0, 2'b00, 12'h044, 32'd0, 0);
            applyStimulus(1, vecs[i].r1, 0, 2'b00, 12'h088, 32'd0, vecs[i].lock);
            #2;
            checkOutput($sformatf("vec%0d p0_gnt", i), p0_gnt, vecs[i].g0);
            checkOutput($sformatf("vec%0d p1_gnt", i), p1_gnt, vecs[i].g1);
            checkOutput($sformatf("vec%0d p0_stall", i), p0_stall, vecs[i].stall);
            checkOutput($sformatf("vec%0d m_addr", i), m_addr,
                        vecs[i].g0 ? 32'h044 : (vecs[i].g1 ? 32'h088 : 32'h0));
            tick();
        end

        // Reset right after a granted load drops its rvalid.
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 2'b00, 12'h000, 32'd0, 0);
        applyStimulus(0, 1, 0, 2'b00, 12'h010, 32'd0, 0);
        #2;
        checkOutput("rstld p0_gnt", p0_gnt, 1);
        tick();
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 2'b00, 12'h000, 32'd0, 0);
        #2;
        checkOutput("rstld rvalid dropped", p0_rvalid, 0);
        tick();
        checkOutput("rstld rvalid after", p0_rvalid, 0);
        checkOutput("rstld rdata cleared", p0_rdata, 0);
        rst_n = 1'b1;
        applyStimulus(0, 1, 0, 2'b00, 12'h010, 32'd0, 0);
        applyStimulus(1, 1, 0, 2'b00, 12'h020, 32'd0, 0);
        #2;
        checkOutput("post rst p0_gnt", p0_gnt, 1);
        checkOutput("post rst p1_gnt", p1_gnt, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
